// File: rtl/taxi_disp_pkg.sv
// Shared constants for the taxi meter display: select codes, 7-segment
// patterns (active-low, seg[7] = dp, seg[6:0] = gfedcba) and per-quantity
// formatting (decimal-point position, digits always shown).
package taxi_disp_pkg;

    localparam logic [1:0] SEL_MONEY = 2'd0;
    localparam logic [1:0] SEL_RUN   = 2'd1;
    localparam logic [1:0] SEL_WAIT  = 2'd2;
    localparam logic [1:0] SEL_LAMP  = 2'd3;

    localparam int NUM_DIGITS = 6;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Decimal-point digit per quantity; DP_POS_NONE never matches a slot.
    localparam int DP_POS_MONEY = 1;  // xxxx.x yuan
    localparam int DP_POS_RUN   = 3;  // xx.xxx km
    localparam int DP_POS_NONE  = NUM_DIGITS;

    // Highest digit index that is never blanked.
    localparam int KEEP_MONEY = 1;
    localparam int KEEP_RUN   = 3;
    localparam int KEEP_WAIT  = 0;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic int dp_pos(input logic [1:0] s);
        int p;
        case (s)
            SEL_MONEY: p = DP_POS_MONEY;
            SEL_RUN:   p = DP_POS_RUN;
            default:   p = DP_POS_NONE;
        endcase
        return p;
    endfunction

    function automatic int keep_digits(input logic [1:0] s);
        int k;
        case (s)
            SEL_MONEY: k = KEEP_MONEY;
            SEL_RUN:   k = KEEP_RUN;
            default:   k = KEEP_WAIT;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/bin2bcd18.sv
// Iterative double-dabble converter: 18-bit binary to 6 BCD digits.
// start in IDLE -> LOAD -> 18 x SHIFT -> DONE; dout/done are registered
// so the result appears one cycle after DONE.
module bin2bcd18 (
    input  logic        cp,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] din,
    output logic        busy,
    output logic        done,
    output logic [23:0] dout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [23:0] work;
    logic [17:0] value;
    logic [23:0] adj;

    function automatic logic [23:0] add3(input logic [23:0] w);
        logic [23:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = (w[i*4 +: 4] >= 4'd5) ? w[i*4 +: 4] + 4'd3 : w[i*4 +: 4];
        end
        return r;
    endfunction

    // Nibble correction applied before every shift
    always_comb adj = add3(work);

    assign busy = (state != ST_IDLE);

    // Sequencer, bit counter and result register
    always_ff @(posedge cp) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
            done  <= 1'b0;
            dout  <= 24'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE:  if (start) state <= ST_LOAD;
                ST_LOAD: begin
                    cnt   <= 5'd0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd17) state <= ST_DONE;
                end
                default: begin
                    dout  <= work;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Work/shift datapath; cleared on LOAD, so it needs no reset
    always_ff @(posedge cp) begin
        if (state == ST_LOAD) begin
            work  <= 24'd0;
            value <= din;
        end else if (state == ST_SHIFT) begin
            {work, value} <= {adj[22:0], value, 1'b0};
        end
    end

endmodule

// File: rtl/taxi_display.sv
// Taxi meter display: samples the selected meter quantity once per frame,
// converts it to BCD and scans it onto a 6-digit active-low 7-segment
// display with per-quantity decimal point, leading-zero blanking and
// lamp test.
module taxi_display
    import taxi_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        cp,
    input  logic        reset,
    input  logic [1:0]  sel,
    input  logic [13:0] money,
    input  logic [17:0] run,
    input  logic [15:0] waitTime,
    output logic [7:0]  seg,
    output logic [5:0]  an,
    output logic [23:0] bcd,
    output logic        busy
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] count;
    logic          tick;
    logic [2:0]    idx;
    logic          frame_start;

    logic [1:0]    sel_cap;
    logic [1:0]    sel_disp;
    logic [17:0]   sel_value;
    logic [17:0]   value_cap;

    logic          conv_done;
    logic [23:0]   conv_dout;

    logic [5:0]    blank;
    logic [3:0]    digit;
    logic          digit_blank;
    logic [7:0]    seg_next;

    assign tick        = (count == PW'(SCAN_DIV - 1));
    assign frame_start = tick && (idx == 3'd5);

    // Digit-slot prescaler and scan index
    always_ff @(posedge cp) begin
        if (reset) begin
            count <= '0;
            idx   <= 3'd0;
        end else begin
            count <= tick ? '0 : count + PW'(1);
            if (tick) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

    // Quantity chosen by the live select, zero-extended to 18 bits
    always_comb begin
        sel_value = 18'd0;
        case (sel)
            SEL_MONEY: sel_value = {4'd0, money};
            SEL_RUN:   sel_value = run;
            SEL_WAIT:  sel_value = {2'd0, waitTime};
            default:   sel_value = 18'd0;
        endcase
    end

    // Freeze select and operand at frame start so later input changes wait a frame
    always_ff @(posedge cp) begin
        if (frame_start) begin
            sel_cap   <= sel;
            value_cap <= sel_value;
        end
    end

    bin2bcd18 u_conv (
        .cp    (cp),
        .reset (reset),
        .start (frame_start),
        .din   (value_cap),
        .busy  (busy),
        .done  (conv_done),
        .dout  (conv_dout)
    );

    // Publish a finished conversion together with its display format
    always_ff @(posedge cp) begin
        if (reset) begin
            bcd      <= 24'd0;
            sel_disp <= SEL_MONEY;
        end else if (conv_done) begin
            bcd      <= conv_dout;
            sel_disp <= sel_cap;
        end
    end

    // Leading-zero blanking and segment pattern for the current slot
    always_comb begin
        logic zero_hi;
        zero_hi     = 1'b1;
        blank       = 6'd0;
        digit       = 4'd0;
        digit_blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_hi  = zero_hi && (bcd[i*4 +: 4] == 4'd0);
            blank[i] = zero_hi && (i > keep_digits(sel_disp));
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                digit       = bcd[i*4 +: 4];
                digit_blank = blank[i];
            end
        end
        if (sel == SEL_LAMP) begin
            seg_next = 8'h00;
        end else if (digit_blank) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = seg_code(digit);
            if (dp_pos(sel_disp) == int'(idx)) seg_next[7] = 1'b0;
        end
    end

    // Registered digit drive
    always_ff @(posedge cp) begin
        if (reset) begin
            an  <= 6'b111111;
            seg <= 8'hFF;
        end else begin
            an  <= ~(6'b000001 << idx);
            seg <= seg_next;
        end
    end

endmodule
